// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its command sequencer.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHR  = 2'b10,
        OP_SHL  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/usr_shift_register.sv
// 4-mode universal shift register: hold, shift right (serial in at MSB), shift left (serial in at LSB), load.
module Universal_Shift_Register
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut
);

    // No reset: contents must survive a sequencer reset.
    always_ff @(posedge clock) begin
        case (MODE)
            MODE_SHR:  DataOut <= {DataIn[0], DataOut[WIDTH-1:1]};
            MODE_SHL:  DataOut <= {DataOut[WIDTH-2:0], DataIn[0]};
            MODE_LOAD: DataOut <= DataIn;
            default:   DataOut <= DataOut;
        endcase
    end

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer: turns clear/load/shift/rotate commands into per-cycle
// MODE/DataIn drive for the universal shift register, then pulses done.
module usr_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_rot,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_abort,
    output logic [1:0]       usr_mode,
    output logic [WIDTH-1:0] usr_din,
    input  logic [WIDTH-1:0] usr_dout,
    output logic             busy,
    output logic             done
);

    state_e             state;
    op_e                op_q;
    logic               rot_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   remaining;

    logic accept;
    logic is_shift;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign is_shift  = cmd_op[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_CLR;
            rot_q     <= 1'b0;
            data_q    <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    op_q   <= op_e'(cmd_op);
                    rot_q  <= cmd_rot;
                    data_q <= cmd_data;
                    // A zero-count shift completes without ever driving the register.
                    if (is_shift && cmd_count == '0) begin
                        remaining <= '0;
                        done      <= 1'b1;
                    end else begin
                        remaining <= is_shift ? cmd_count : CNT_W'(1);
                        state     <= ST_RUN;
                    end
                end
            end else if (cmd_abort) begin
                state     <= ST_IDLE;
                remaining <= '0;
            end else begin
                remaining <= remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    // Rotate bit comes straight from the live register output.
    always_comb begin
        usr_mode = MODE_HOLD;
        usr_din  = '0;
        if (state == ST_RUN) begin
            case (op_q)
                OP_CLR: usr_mode = MODE_LOAD;
                OP_LOAD: begin
                    usr_mode = MODE_LOAD;
                    usr_din  = data_q;
                end
                OP_SHR: begin
                    usr_mode   = MODE_SHR;
                    usr_din[0] = rot_q ? usr_dout[0] : data_q[0];
                end
                OP_SHL: begin
                    usr_mode   = MODE_SHL;
                    usr_din[0] = rot_q ? usr_dout[WIDTH-1] : data_q[0];
                end
                default: usr_mode = MODE_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench: sequencer driving a real universal shift register, checked against hand-computed values.
module tb_usr_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_rot;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_abort;
    logic [1:0]       usr_mode;
    logic [WIDTH-1:0] usr_din;
    logic [WIDTH-1:0] usr_dout;
    logic             busy;
    logic             done;

    int vectors = 0;
    int miscompares = 0;

    usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rot(cmd_rot), .cmd_count(cmd_count), .cmd_data(cmd_data),
        .cmd_abort(cmd_abort),
        .usr_mode(usr_mode), .usr_din(usr_din), .usr_dout(usr_dout),
        .busy(busy), .done(done)
    );

    Universal_Shift_Register #(.WIDTH(WIDTH)) sreg (
        .clock(clock), .MODE(usr_mode), .DataIn(usr_din), .DataOut(usr_dout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command, let it be accepted on the next edge, then drop valid.
    task automatic issue(input logic [1:0] op, input logic rot, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rot   = rot;
        cmd_count = cnt;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        #0;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rot = 1'b0;
        cmd_count = '0; cmd_data = '0; cmd_abort = 1'b0;
        tick(); tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mode", usr_mode, 2'b00);
        check("rst_din", usr_din, 0);
        reset = 1'b1;
        tick();

        // LOAD 1010
        issue(2'b01, 1'b0, 4'd0, 4'b1010);
        check("load_busy", busy, 1);
        check("load_mode", usr_mode, 2'b11);
        check("load_din", usr_din, 4'b1010);
        tick();
        check("load_dout", usr_dout, 4'b1010);
        check("load_done", done, 1);
        check("load_busy_end", busy, 0);
        tick();
        check("load_done_pulse", done, 0);

        // CLR, then SHR fill 1 count 2
        issue(2'b00, 1'b0, 4'd7, 4'b1111);
        check("clr_din", usr_din, 0);
        tick();
        check("clr_dout", usr_dout, 4'b0000);
        issue(2'b10, 1'b0, 4'd2, 4'b0001);
        check("shr_mode", usr_mode, 2'b01);
        check("shr_din", usr_din, 4'b0001);
        tick();
        check("shr_1", usr_dout, 4'b1000);
        check("shr_1_done", done, 0);
        tick();
        check("shr_2", usr_dout, 4'b1100);
        check("shr_2_done", done, 1);

        // CLR, then SHL fill 1 count 2
        issue(2'b00, 1'b0, 4'd0, 4'b0000);
        tick();
        issue(2'b11, 1'b0, 4'd2, 4'b0001);
        check("shl_mode", usr_mode, 2'b10);
        tick();
        check("shl_1", usr_dout, 4'b0001);
        tick();
        check("shl_2", usr_dout, 4'b0011);
        check("shl_2_done", done, 1);

        // LOAD 1001, SHR rotate 3, SHL rotate 4
        issue(2'b01, 1'b0, 4'd0, 4'b1001);
        tick();
        issue(2'b10, 1'b1, 4'd3, 4'b0000);
        check("rotr_din0", usr_din, 4'b0001);
        tick();
        check("rotr_1", usr_dout, 4'b1100);
        check("rotr_din1", usr_din, 4'b0000);
        tick();
        check("rotr_2", usr_dout, 4'b0110);
        tick();
        check("rotr_3", usr_dout, 4'b0011);
        check("rotr_done", done, 1);
        issue(2'b11, 1'b1, 4'd4, 4'b0000);
        tick();
        check("rotl_1", usr_dout, 4'b0110);
        tick();
        check("rotl_2", usr_dout, 4'b1100);
        tick();
        check("rotl_3", usr_dout, 4'b1001);
        check("rotl_3_done", done, 0);
        tick();
        check("rotl_4", usr_dout, 4'b0011);
        check("rotl_done", done, 1);

        // Zero-count shift
        issue(2'b10, 1'b0, 4'd0, 4'b0001);
        check("zero_mode", usr_mode, 2'b00);
        check("zero_busy", busy, 0);
        check("zero_done", done, 1);
        check("zero_dout", usr_dout, 4'b0011);
        tick();
        check("zero_done_end", done, 0);
        check("zero_dout_end", usr_dout, 4'b0011);

        // SHL fill 0 count 9 from 1111 saturates to 0000
        issue(2'b01, 1'b0, 4'd0, 4'b1111);
        tick();
        issue(2'b11, 1'b0, 4'd9, 4'b0000);
        for (int i = 0; i < 8; i++) tick();
        check("c9_busy8", busy, 1);
        check("c9_done8", done, 0);
        tick();
        check("c9_dout", usr_dout, 4'b0000);
        check("c9_done", done, 1);

        // Abort in second cycle of SHR count 4 from 1000
        issue(2'b01, 1'b0, 4'd0, 4'b1000);
        tick();
        issue(2'b10, 1'b0, 4'd4, 4'b0000);
        tick();
        check("abt_1", usr_dout, 4'b0100);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        #0;
        check("abt_dout", usr_dout, 4'b0010);
        check("abt_busy", busy, 0);
        check("abt_done", done, 0);
        check("abt_mode", usr_mode, 2'b00);
        tick();
        check("abt_hold", usr_dout, 4'b0010);
        check("abt_done2", done, 0);

        // Back-to-back with valid held: LOAD 0101 then SHL fill 0 count 1
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rot = 1'b0; cmd_count = 4'd0; cmd_data = 4'b0101;
        tick();
        cmd_op = 2'b11; cmd_count = 4'd1; cmd_data = 4'b0000;
        #0;
        check("b2b_stall_ready", cmd_ready, 0);
        tick();
        check("b2b_first_done", done, 1);
        check("b2b_first_dout", usr_dout, 4'b0101);
        check("b2b_gap_mode", usr_mode, 2'b00);
        tick();
        check("b2b_second_busy", busy, 1);
        check("b2b_second_mode", usr_mode, 2'b10);
        cmd_valid = 1'b0;
        tick();
        check("b2b_second_dout", usr_dout, 4'b1010);
        check("b2b_second_done", done, 1);

        // Reset mid-RUN: register keeps its contents
        issue(2'b10, 1'b1, 4'd4, 4'b0000);
        tick();
        check("mid_1", usr_dout, 4'b0101);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mode", usr_mode, 2'b00);
        check("mid_rst_done", done, 0);
        tick();
        tick();
        check("mid_rst_hold", usr_dout, 4'b0101);
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usr_sequencer.md
# usr_sequencer

Command sequencer for the 4-bit universal shift register (mode encoding 00 hold, 01 shift right, 10 shift left, 11 parallel load). It accepts one command at a time over a valid/ready handshake and drives the register's mode and data inputs for the required number of cycles: clear, load, N-bit shift, or N-bit rotate. It reads the register output back for rotation, then pulses done. It sits between the control logic and the register; the register itself stays a separate instance.

## Interface
- WIDTH, 4: register width, must be ≥ 2.
- CNT_W, 4: width of the shift-count field (max count 2^CNT_W−1).

- clock  input  1  rising-edge clock shared with the shift register.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  00 CLR, 01 LOAD, 10 SHR, 11 SHL.
- cmd_rot  input  1  shifts only: 1 rotates, 0 fills with cmd_data[0].
- cmd_count  input  CNT_W  number of shift cycles; ignored for CLR and LOAD.
- cmd_data  input  WIDTH  load value, or fill bit in [0].
- cmd_abort  input  1  terminate the running command.
- usr_mode  output  2  to register MODE.
- usr_din  output  WIDTH  to register DataIn.
- usr_dout  input  WIDTH  from register DataOut.
- busy  output  1  command executing.
- done  output  1  one-cycle completion pulse.

## Operation
- **FSM states:** IDLE and RUN.
- **Accept rule:** a command is accepted on a rising edge when cmd_valid && cmd_ready. cmd_ready = (state == IDLE).
- **Latched at accept:** op, rot, data, remaining count. Remaining count is 1 for CLR and LOAD, cmd_count for shifts.
- **Zero-count shift:** count 0 stays in IDLE. done pulses in the next cycle and the register is never touched.
- **Register drive while in RUN:**
  - CLR: usr_mode = 11, usr_din = 0.
  - LOAD: usr_mode = 11, usr_din = data.
  - SHR: usr_mode = 01.
  - SHL: usr_mode = 10.
- **Register drive outside RUN:** usr_mode = 00 (hold) and usr_din = 0 at all times.
- **Serial bit source (usr_din[0]; upper bits 0):**
  - rot = 0: latched data[0].
  - rot = 1, SHR: usr_dout[0].
  - rot = 1, SHL: usr_dout[WIDTH−1].
  - usr_din is combinational from the latched command and usr_dout. The rotate bit always reflects the current register value.
- **Counting:** each RUN cycle decrements remaining. On the edge where remaining == 1, the FSM goes RUN→IDLE and done is registered high for one cycle.
- **Counts above WIDTH:** legal. Fill mode saturates the register to the fill bit; rotate wraps modulo WIDTH.
- **Abort:** cmd_abort high in RUN goes to IDLE on the next edge and usr_mode returns to 00. The shift on that same edge still occurs, because mode is 01/10 during that cycle. done is not pulsed. cmd_abort is ignored in IDLE.
- **Reset (any time, including mid-command):** state IDLE, remaining 0, latched fields 0. Outputs: done 0, busy 0, cmd_ready 1, usr_mode 00, usr_din 0. The sequencer does not reset the register.

## Timing
- Command accepted at edge T with effective count N ≥ 1:
  - usr_mode is active during cycles T..T+N−1.
  - The register updates on edges T+1..T+N.
  - At edge T+N the state returns to IDLE and done = 1 for one cycle. usr_dout then holds the final value.
- busy = (state == RUN), high for exactly N cycles.
- **Back-to-back commands:** the next command is accepted at the earliest at edge T+N+1. There is one hold cycle between commands. A command held valid during RUN is simply stalled.
- **Latency (accept edge to done):** CLR and LOAD take 1 cycle; shifts take N cycles; count 0 takes 1 cycle with no register change.

## Structure
- **Package usr_pkg:**
  - register mode constants MODE_HOLD / MODE_SHR / MODE_SHL / MODE_LOAD;
  - command op enum OP_CLR / OP_LOAD / OP_SHR / OP_SHL;
  - FSM state enum ST_IDLE / ST_RUN.
- **Sub-modules:** none inside the sequencer; counter and FSM are inline. The bench instantiates usr_sequencer alongside Universal_Shift_Register, wiring usr_mode/usr_din/usr_dout to MODE/DataIn/DataOut.

## Test plan
- **Reset:** reset = 0 mid-RUN → next cycle cmd_ready = 1, busy = 0, done = 0, usr_mode = 00; the register holds its value thereafter.
- **LOAD:** cmd_data = 1010 → usr_dout = 1010 after edge T+1; done high in that same cycle; busy high exactly 1 cycle.
- **Fill shifts:**
  - From 0000, SHR fill, cmd_data[0] = 1, count 2 → usr_dout = 1000 then 1100, done after the second.
  - From 0000, SHL fill 1, count 2 → 0001 then 0011.
- **Rotate:** from LOAD 1001, SHR rot count 3 → 1100, 0110, 0011. Then SHL rot count 4 → 0011 (full wrap).
- **Count edges:** SHR count 0 → done next cycle, usr_mode never leaves 00, usr_dout unchanged. SHL fill 0 count 9 from 1111 → 0000.
- **Abort and back-to-back:**
  - cmd_abort in the second cycle of a count-4 SHR from 1000 → usr_dout = 0010, no done pulse.
  - cmd_valid held continuously with two commands → second accepted exactly one cycle after the first's done edge.
